// File: rtl/disp_scan_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// disp_pkg
// Purpose : shared types and constants for the display scan controller.
// Contents: bcd_t digit type, disp_state_t FSM encoding, SEG_BLANK pattern,
//           width constants and a max helper for counter sizing.
// ---------------------------------------------------------------------------
package disp_pkg;

    localparam int unsigned BCD_W = 4;
    localparam int unsigned SEG_W = 7;

    typedef logic [BCD_W-1:0] bcd_t;

    typedef enum logic [1:0] {
        ST_OFF,
        ST_SHOW,
        ST_BLANK
    } disp_state_t;

    // All segments off; also used for non-BCD nibbles.
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b0000000;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/disp_scan_ctrl_if.sv
// ---------------------------------------------------------------------------
// disp_scan_ctrl_if
// Purpose : load handshake carrying a new set of BCD digits to the scanner.
// Signals : disp_bcd_in     digit k in bits [4k+3:4k], digit 0 rightmost
//           disp_load_valid source offers disp_bcd_in
//           disp_load_ready controller can accept a load
// Modports: master = value source, slave = disp_scan_ctrl.
// ---------------------------------------------------------------------------
interface disp_scan_ctrl_if #(
    parameter int unsigned DIGITS = 4
) ();

    logic [4*DIGITS-1:0] disp_bcd_in;
    logic                disp_load_valid;
    logic                disp_load_ready;

    modport master (
        output disp_bcd_in,
        output disp_load_valid,
        input  disp_load_ready
    );

    modport slave (
        input  disp_bcd_in,
        input  disp_load_valid,
        output disp_load_ready
    );

endinterface

// File: rtl/disp_scan_ctrl_bcd_7seg.sv
// ---------------------------------------------------------------------------
// bcd_7seg
// Purpose : BCD to 7-segment decoder, segments {a,b,c,d,e,f,g} active-high.
//           Nibbles A-F decode to all segments off.
// Ports   : bcd_i  4-bit BCD digit
//           seg_o  7-bit segment pattern
// ---------------------------------------------------------------------------
module bcd_7seg
    import disp_pkg::*;
(
    input  bcd_t             bcd_i,
    output logic [SEG_W-1:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        case (bcd_i)
            4'd0:    seg_o = 7'b1111110;
            4'd1:    seg_o = 7'b0110000;
            4'd2:    seg_o = 7'b1101101;
            4'd3:    seg_o = 7'b1111001;
            4'd4:    seg_o = 7'b0110011;
            4'd5:    seg_o = 7'b1011011;
            4'd6:    seg_o = 7'b1011111;
            4'd7:    seg_o = 7'b1110000;
            4'd8:    seg_o = 7'b1111111;
            4'd9:    seg_o = 7'b1111011;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/disp_scan_ctrl.sv
// ---------------------------------------------------------------------------
// disp_scan_ctrl
// Purpose : time-multiplexed scan controller for a DIGITS-wide common-anode
//           7-segment display with a shared decoder, programmable dwell and
//           inter-digit blanking. New values load through a valid/ready
//           handshake into a shadow buffer and only reach the display at a
//           frame boundary (or immediately while the display is off).
// Ports   : clk, rst_n        clock, async active-low reset
//           disp_en           1 = scan, 0 = dark
//           load_if (slave)   disp_bcd_in / disp_load_valid / disp_load_ready
//           disp_seg_out      segments {a..g}, active-high
//           disp_an_out       anodes, active-low one-hot, all-1 = dark
//           disp_frame_out    1-cycle pulse when the shadow value commits
// Config  : LEADING_ZERO_BLANK_EN darkens leading zero digits (digit 0 always
//           shown); undefined shows every digit.
// ---------------------------------------------------------------------------
module disp_scan_ctrl
    import disp_pkg::*;
#(
    parameter int unsigned DIGITS    = 4,
    parameter int unsigned DWELL_CYC = 50000,
    parameter int unsigned BLANK_CYC = 500
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                disp_en,
    disp_scan_ctrl_if.slave     load_if,
    output logic [SEG_W-1:0]    disp_seg_out,
    output logic [DIGITS-1:0]   disp_an_out,
    output logic                disp_frame_out
);

    localparam int unsigned BUF_W = BCD_W * DIGITS;
    localparam int unsigned CNT_W = $clog2(max_u(DWELL_CYC, BLANK_CYC) + 1);
    localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYC - 1);
    // Wraps when BLANK_CYC is 0; the BLANK state is then unreachable.
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DIGITS - 1);

    disp_state_t      state_q,  state_d;
    logic [IDX_W-1:0] idx_q,    idx_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [BUF_W-1:0] active_q, active_d;
    logic [BUF_W-1:0] shadow_q, shadow_d;
    logic             pend_q,   pend_d;
    logic             frame_q,  frame_d;

    logic             boundary;
    logic [IDX_W-1:0] idx_next;
    bcd_t             cur_bcd;
    logic [SEG_W-1:0] dec_seg;
    logic             digit_dark;

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_OFF;
            idx_q    <= '0;
            cnt_q    <= '0;
            active_q <= '0;
            shadow_q <= '0;
            pend_q   <= 1'b0;
            frame_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            active_q <= active_d;
            shadow_q <= shadow_d;
            pend_q   <= pend_d;
            frame_q  <= frame_d;
        end
    end

    assign idx_next = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);

    // Scan sequencing, shadow commit and load acceptance
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        active_d = active_q;
        shadow_d = shadow_q;
        pend_d   = pend_q;
        frame_d  = 1'b0;
        boundary = 1'b0;

        if (!disp_en) begin
            state_d = ST_OFF;
            idx_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_OFF: begin
                    state_d = ST_SHOW;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
                ST_SHOW: begin
                    if (cnt_q == DWELL_LAST) begin
                        cnt_d = '0;
                        if (BLANK_CYC != 0) begin
                            state_d = ST_BLANK;
                        end else begin
                            idx_d    = idx_next;
                            boundary = (idx_q == IDX_LAST);
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_BLANK: begin
                    if (cnt_q == BLANK_LAST) begin
                        cnt_d    = '0;
                        state_d  = ST_SHOW;
                        idx_d    = idx_next;
                        boundary = (idx_q == IDX_LAST);
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = ST_OFF;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
            endcase
        end

        // While dark there is no frame to tear, so a pending load commits at once.
        if (state_q == ST_OFF) begin
            boundary = 1'b1;
        end

        // Commit needs pend_q=1 and accept needs pend_q=0, so they never collide.
        if (boundary && pend_q) begin
            active_d = shadow_q;
            pend_d   = 1'b0;
            frame_d  = 1'b1;
        end else if (load_if.disp_load_valid && !pend_q) begin
            shadow_d = load_if.disp_bcd_in;
            pend_d   = 1'b1;
        end
    end

    assign load_if.disp_load_ready = ~pend_q;
    assign disp_frame_out          = frame_q;

    assign cur_bcd = active_q[BCD_W*idx_q +: BCD_W];

    bcd_7seg u_dec (
        .bcd_i (cur_bcd),
        .seg_o (dec_seg)
    );

`ifdef LEADING_ZERO_BLANK_EN
    logic [DIGITS-1:0] lz_dark;
    logic              zero_run;

    // Digit k>0 is dark when it and every digit above it hold zero.
    always_comb begin
        lz_dark  = '0;
        zero_run = 1'b1;
        for (int k = int'(DIGITS) - 1; k > 0; k--) begin
            zero_run   = zero_run && (active_q[BCD_W*k +: BCD_W] == 4'd0);
            lz_dark[k] = zero_run;
        end
    end

    assign digit_dark = lz_dark[idx_q];
`else
    assign digit_dark = 1'b0;
`endif

    // Pin drive derived only from registered state
    always_comb begin
        disp_an_out  = '1;
        disp_seg_out = SEG_BLANK;
        if (state_q == ST_SHOW && !digit_dark) begin
            disp_an_out[idx_q] = 1'b0;
            disp_seg_out       = dec_seg;
        end
    end

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_disp_scan_ctrl
// Purpose : self-checking bench for disp_scan_ctrl (DIGITS=4, DWELL=4,
//           BLANK=1). A timeline reference tracks cycles since enable and
//           derives the lit digit from position within the frame.
// ---------------------------------------------------------------------------
module tb_disp_scan_ctrl;
    import disp_pkg::*;

    localparam int unsigned DIGITS  = 4;
    localparam int unsigned DWELL   = 4;
    localparam int unsigned BLANK   = 1;
    localparam int          P_DIGIT = int'(DWELL + BLANK);
    localparam int          P_FRAME = int'(DIGITS) * P_DIGIT;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        disp_en;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        frame;

    int checks   = 0;
    int failures = 0;

    // Reference state
    bit          m_on;
    int          m_t;
    logic [15:0] m_active;
    logic [15:0] m_shadow;
    bit          m_pend;
    bit          m_frame;
    bit          m_acc;

    disp_scan_ctrl_if #(.DIGITS(DIGITS)) load_if ();

    disp_scan_ctrl #(
        .DIGITS    (DIGITS),
        .DWELL_CYC (DWELL),
        .BLANK_CYC (BLANK)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .disp_en        (disp_en),
        .load_if        (load_if),
        .disp_seg_out   (seg),
        .disp_an_out    (an),
        .disp_frame_out (frame)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] ref_seg(input logic [3:0] v);
        case (v)
            4'd0: return 7'b1111110;
            4'd1: return 7'b0110000;
            4'd2: return 7'b1101101;
            4'd3: return 7'b1111001;
            4'd4: return 7'b0110011;
            4'd5: return 7'b1011011;
            4'd6: return 7'b1011111;
            4'd7: return 7'b1110000;
            4'd8: return 7'b1111111;
            4'd9: return 7'b1111011;
            default: return 7'b0000000;
        endcase
    endfunction

    task automatic model_reset();
        m_on = 0; m_t = 0; m_active = '0; m_shadow = '0;
        m_pend = 0; m_frame = 0; m_acc = 0;
    endtask

    // One clock edge of the reference, using inputs held before the edge.
    task automatic model_step();
        bit commit;
        commit = 0;
        if (m_pend && !m_on) commit = 1;
        if (m_pend && m_on && disp_en && (m_t % P_FRAME) == P_FRAME - 1) commit = 1;
        m_frame = commit;
        m_acc   = 0;
        if (commit) begin
            m_active = m_shadow;
            m_pend   = 0;
        end else if (load_if.disp_load_valid && !m_pend) begin
            m_shadow = load_if.disp_bcd_in;
            m_pend   = 1;
            m_acc    = 1;
        end
        if (!disp_en) begin
            m_on = 0; m_t = 0;
        end else if (!m_on) begin
            m_on = 1; m_t = 0;
        end else begin
            m_t++;
        end
    endtask

    function automatic void exp_outputs(output logic [3:0] ean, output logic [6:0] eseg);
        int pos, d;
        logic [3:0] v;
        bit dark;
        ean = 4'b1111; eseg = 7'b0;
        if (!m_on) return;
        pos = m_t % P_FRAME;
        d   = pos / P_DIGIT;
        if ((pos % P_DIGIT) >= int'(DWELL)) return;
        v    = m_active[4*d +: 4];
        dark = 0;
`ifdef LEADING_ZERO_BLANK_EN
        if (d > 0 && (m_active >> (4*d)) == 16'h0) dark = 1;
`endif
        if (dark) return;
        ean  = ~(4'b0001 << d);
        eseg = ref_seg(v);
    endfunction

    task automatic check_all(input string tag);
        logic [3:0] ean;
        logic [6:0] eseg;
        exp_outputs(ean, eseg);
        checks++;
        assert (an === ean) else begin
            failures++; $error("FAIL %s an got=%b exp=%b t=%0d", tag, an, ean, m_t);
        end
        checks++;
        assert (seg === eseg) else begin
            failures++; $error("FAIL %s seg got=%b exp=%b t=%0d", tag, seg, eseg, m_t);
        end
        checks++;
        assert (load_if.disp_load_ready === !m_pend) else begin
            failures++; $error("FAIL %s ready got=%b exp=%b", tag, load_if.disp_load_ready, !m_pend);
        end
        checks++;
        assert (frame === m_frame) else begin
            failures++; $error("FAIL %s frame got=%b exp=%b", tag, frame, m_frame);
        end
    endtask

    task automatic cycle(input string tag);
        @(posedge clk);
        model_step();
        #1;
        check_all(tag);
    endtask

    task automatic run(input string tag, input int n);
        for (int i = 0; i < n; i++) cycle(tag);
    endtask

    // Advance until the reference sits at a given frame position (bounded).
    task automatic run_to_pos(input string tag, input int pos);
        for (int i = 0; i < P_FRAME && (m_t % P_FRAME) != pos; i++) cycle(tag);
    endtask

    // Offer a value for exactly one accepting edge.
    task automatic load(input string tag, input logic [15:0] v);
        load_if.disp_bcd_in     = v;
        load_if.disp_load_valid = 1'b1;
        cycle(tag);
        load_if.disp_load_valid = 1'b0;
    endtask

    function automatic logic [15:0] rand_bcd();
        logic [15:0] r;
        for (int k = 0; k < 4; k++)
            r[4*k +: 4] = ($urandom_range(0, 15) < 6) ? 4'd0 : 4'($urandom_range(0, 15));
        return r;
    endfunction

    initial begin
        rst_n = 1'b0;
        disp_en = 1'b0;
        load_if.disp_bcd_in = '0;
        load_if.disp_load_valid = 1'b0;
        model_reset();
        #12;
        check_all("reset");
        rst_n = 1'b1;
        run("idle", 2);

        // Load while dark, then enable
        load("t2_accept", 16'h1234);
        cycle("t2_commit");
        checks++;
        assert (frame === 1'b1) else begin
            failures++; $error("FAIL t2_frame got=%b exp=1", frame);
        end
        disp_en = 1'b1;
        cycle("t2_d0");
        checks++;
        assert (an === 4'b1110 && seg === 7'b0110011) else begin
            failures++; $error("FAIL t2_d0_lit got=%b/%b exp=1110/0110011", an, seg);
        end
        run("t2_scan", 2 * P_FRAME);

        // Load during digit 1 SHOW; commit waits for frame boundary
        run_to_pos("t3_seek", P_DIGIT + 1);
        load("t3_accept", 16'h5678);
        run("t3_scan", 2 * P_FRAME);

        // Non-BCD nibble on digit 1
        load("t4_accept", 16'h00A0);
        run("t4_scan", 2 * P_FRAME);

        // Disable mid digit 2, then re-enable
        run_to_pos("t5_seek", 2 * P_DIGIT + 2);
        disp_en = 1'b0;
        cycle("t5_off");
        checks++;
        assert (an === 4'b1111 && seg === 7'b0) else begin
            failures++; $error("FAIL t5_dark got=%b/%b exp=1111/0000000", an, seg);
        end
        disp_en = 1'b1;
        run("t5_reen", P_FRAME);

        // Leading zeros
        load("t6_accept", 16'h0050);
        run("t6_scan", 2 * P_FRAME);

        // Async reset in the middle of a SHOW phase
        run_to_pos("t1_seek", P_DIGIT + 1);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("t1_async_rst");
        #1;
        disp_en = 1'b0;
        rst_n = 1'b1;
        run("t1_post", 2);
        disp_en = 1'b1;

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if (!load_if.disp_load_valid || m_acc) begin
                load_if.disp_load_valid = ($urandom_range(0, 3) == 0);
                load_if.disp_bcd_in     = rand_bcd();
            end
            disp_en = ($urandom_range(0, 31) != 0);
            cycle("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
